// File: rtl/ex_trap_pkg.sv
// Shared types and helpers for the external-trap arbiter.
// Holds the arbiter state encoding, the source-count ceiling and the
// round-robin pick function used by ex_trap_arbiter.
package ex_trap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int SRC_NUM_MAX = 32;

    // Returns the first set bit of req at or after (last+1), wrapping at n.
    // Starting the search at last+1 gives the previous winner lowest priority.
    // Callers guarantee last < n; the result is 0 when req is empty.
    function automatic logic [4:0] rr_pick(input logic [SRC_NUM_MAX-1:0] req,
                                           input logic [4:0]             last,
                                           input int                     n);
        logic [4:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= SRC_NUM_MAX; i++) begin
            idx = int'(last) + i;
            if (idx >= n) idx = idx - n;
            if (idx >= n) idx = idx - n;
            if ((i <= n) && !found && req[idx]) begin
                pick  = 5'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ex_trap_sync_edge.sv
// Per-source capture cell: SYNC_STAGES-deep synchroniser for an
// asynchronous interrupt pin followed by a rising-edge detector.
// edge_o is a one-cycle pulse in the clk domain.
module trap_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw pin through the synchroniser and keep one cycle of history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ex_trap_arbiter.sv
// External interrupt collector for the core trap input.
// Each source is synchronised, edge detected and latched as pending; pending
// sources are granted round-robin over a valid/ready handshake with a
// one-cycle gap after every accepted trap.
// Optional feature macro: EX_TRAP_MASK_EN adds a writable enable mask
// (reset all-ones); without it every source is always enabled.
module ex_trap_arbiter
    import ex_trap_pkg::*;
#(
    parameter  int SRC_NUM     = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = $clog2(SRC_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SRC_NUM-1:0] src_i,
    output logic               trap_valid_o,
    input  logic               trap_ready_i,
    output logic [ID_W-1:0]    trap_id_o,
`ifdef EX_TRAP_MASK_EN
    input  logic               mask_we_i,
    input  logic [SRC_NUM-1:0] mask_wdata_i,
    output logic [SRC_NUM-1:0] mask_o,
`endif
    output logic [SRC_NUM-1:0] pend_o
);

    logic [SRC_NUM-1:0] edge_vec;
    logic [SRC_NUM-1:0] mask_vec;
    logic [SRC_NUM-1:0] arb_req;
    logic [SRC_NUM-1:0] clr_vec;
    logic [SRC_NUM-1:0] pend_q, pend_d;
    logic               valid_q, valid_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    pick_id;
    state_e             state_q, state_d;

    for (genvar n = 0; n < SRC_NUM; n++) begin : g_src
        trap_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .rst     (rst),
            .async_i (src_i[n]),
            .edge_o  (edge_vec[n])
        );
    end

`ifdef EX_TRAP_MASK_EN
    logic [SRC_NUM-1:0] mask_q;

    // Software-writable enable mask; masked sources still collect pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mask_q <= '1;
        else if (mask_we_i) mask_q <= mask_wdata_i;
    end

    assign mask_vec = mask_q;
    assign mask_o   = mask_q;
`else
    assign mask_vec = '1;
`endif

    assign arb_req = pend_q & mask_vec;
    assign pick_id = ID_W'(rr_pick(SRC_NUM_MAX'(arb_req), 5'(last_q), SRC_NUM));

    // Arbiter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: request only from IDLE, hold REQ until accepted, one GAP cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|arb_req)    state_d = REQ;
            REQ:     if (trap_ready_i) state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: launch a request on a pick, retire it on ready.
    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        last_d  = last_q;
        clr_vec = '0;
        case (state_q)
            IDLE: begin
                if (|arb_req) begin
                    valid_d = 1'b1;
                    id_d    = pick_id;
                end
            end
            REQ: begin
                if (trap_ready_i) begin
                    valid_d      = 1'b0;
                    last_d       = id_q;
                    clr_vec[id_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A new edge in the clearing cycle wins, so the source is never lost.
    assign pend_d = (pend_q & ~clr_vec) | edge_vec;

    // Request, id, rr pointer and pending registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            last_q  <= ID_W'(SRC_NUM - 1);
            pend_q  <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
        end
    end

    assign trap_valid_o = valid_q;
    assign trap_id_o    = id_q;
    assign pend_o       = pend_q;

endmodule

// File: tb/tb_ex_trap_arbiter.sv
// Self-checking bench for ex_trap_arbiter (SRC_NUM=4, SYNC_STAGES=2).
// Expected grant ids go into a queue at stimulus time; a monitor pops and
// compares on every accepted handshake and checks the following gap cycle.
module tb_ex_trap_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src;
    logic       ready;
    logic       valid;
    logic [1:0] id;
    logic [3:0] pend;
`ifdef EX_TRAP_MASK_EN
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic [3:0] mask;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    ex_trap_arbiter #(.SRC_NUM(4), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_i        (src),
        .trap_valid_o (valid),
        .trap_ready_i (ready),
        .trap_id_o    (id),
`ifdef EX_TRAP_MASK_EN
        .mask_we_i    (mask_we),
        .mask_wdata_i (mask_wdata),
        .mask_o       (mask),
`endif
        .pend_o       (pend)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, input int bound);
        int c;
        c = 0;
        @(negedge clk);
        while (!valid && c < bound) begin
            @(negedge clk);
            c++;
        end
        if (!valid) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: valid not seen within %0d cycles", nm, bound);
        end
    endtask

    task automatic wait_qempty(input string nm, input int bound);
        int c;
        c = 0;
        @(negedge clk);
        while (exp_q.size() != 0 && c < bound) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: %0d grants outstanding after %0d cycles", nm, exp_q.size(), bound);
        end
    endtask

    task automatic idle_check(input string nm, input int cycles);
        int saw;
        saw = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (valid) saw = 1;
        end
        chk(nm, saw, 0);
    endtask

    // Scoreboard monitor: compare each accepted id, then require a low-valid gap.
    initial begin
        int e;
        int gap_chk;
        gap_chk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap_chk = 0;
            end else begin
                if (gap_chk != 0) begin
                    chk("gap_valid_low", int'(valid), 0);
                    gap_chk = 0;
                end
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_grant: got id %0d, expected none", id);
                    end else begin
                        e = exp_q.pop_front();
                        chk("grant_id", int'(id), e);
                    end
                    gap_chk = 1;
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        src   = 4'hF;
        ready = 1'b0;
`ifdef EX_TRAP_MASK_EN
        mask_we    = 1'b0;
        mask_wdata = 4'h0;
`endif
        // Reset state with all lines high
        tick(3);
        @(negedge clk);
        chk("rst_valid", int'(valid), 0);
        chk("rst_pend", int'(pend), 0);
        chk("rst_id", int'(id), 0);
        src = 4'h0;
        tick(1);
        rst = 1'b0;
        idle_check("idle_no_valid", 8);
        chk("idle_pend", int'(pend), 0);

        // Single source 2: pend at k+2, valid at k+3
        tick(1);
        src[2] = 1'b1;
        tick(3);
        @(negedge clk);
        chk("lat_pend_set", int'(pend), 4);
        chk("lat_valid_not_yet", int'(valid), 0);
        tick(1);
        @(negedge clk);
        chk("lat_valid", int'(valid), 1);
        chk("lat_id", int'(id), 2);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            @(negedge clk);
            chk("hold_stable", int'({valid, id}), 6);
        end
        tick(1);
        exp_q.push_back(2);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        @(negedge clk);
        chk("ack_pend_clr", int'(pend), 0);
        chk("ack_valid_low", int'(valid), 0);
        idle_check("level_no_repend", 10);
        src = 4'h0;

        // Round robin from a fresh reset: 0,1,3 then 0,3
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        ready = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        src = 4'b1011;
        tick(3);
        src = 4'h0;
        wait_qempty("rr_first", 40);
        tick(2);
        exp_q.push_back(0);
        exp_q.push_back(3);
        src = 4'b1001;
        tick(3);
        src = 4'h0;
        wait_qempty("rr_second", 40);
        tick(4);
        @(negedge clk);
        chk("rr_pend_empty", int'(pend), 0);

        // Coalesce: three pulses on src 1 while pending give one grant
        tick(1);
        ready = 1'b0;
        exp_q.push_back(1);
        repeat (3) begin
            src[1] = 1'b1;
            tick(2);
            src[1] = 1'b0;
            tick(2);
        end
        @(negedge clk);
        chk("coal_req", int'({valid, id}), 5);
        chk("coal_pend", int'(pend), 2);
        tick(1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        wait_qempty("coal_grant", 5);
        idle_check("coal_single", 10);

        // Collision: new edge on src 1 in its clearing cycle re-pends it
        tick(1);
        exp_q.push_back(1);
        src[1] = 1'b1;
        tick(2);
        src[1] = 1'b0;
        wait_valid("coll_req", 20);
        tick(3);
        src[1] = 1'b1;
        exp_q.push_back(1);
        tick(2);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        src[1] = 1'b0;
        @(negedge clk);
        chk("coll_pend_kept", int'(pend), 2);
        tick(1);
        ready = 1'b1;
        wait_qempty("coll_second", 20);
        tick(1);
        ready = 1'b0;

`ifdef EX_TRAP_MASK_EN
        // Masked source latches pend but is not arbitrated
        tick(1);
        mask_we    = 1'b1;
        mask_wdata = 4'b1110;
        tick(1);
        mask_we = 1'b0;
        @(negedge clk);
        chk("mask_write", int'(mask), 14);
        tick(1);
        src[0] = 1'b1;
        tick(2);
        src[0] = 1'b0;
        tick(5);
        @(negedge clk);
        chk("mask_pend", int'(pend), 1);
        chk("mask_no_valid", int'(valid), 0);
        tick(1);
        exp_q.push_back(0);
        ready      = 1'b1;
        mask_we    = 1'b1;
        mask_wdata = 4'hF;
        tick(1);
        mask_we = 1'b0;
        wait_qempty("mask_grant", 20);
        tick(1);
        ready = 1'b0;
`endif

        // Reset during REQ drops valid without waiting for a clock
        tick(1);
        src[3] = 1'b1;
        tick(2);
        src[3] = 1'b0;
        wait_valid("rstreq_req", 20);
        chk("rstreq_id", int'(id), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("rstreq_async_drop", int'(valid), 0);
        tick(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rstreq_pend", int'(pend), 0);
        chk("rstreq_valid", int'(valid), 0);
        idle_check("rstreq_idle", 6);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
